md5_bf_host_ctrl: RTL and testbench
===================================

# md5_bf_host_ctrl

Host-side controller for the MD5 brute-force core. It accepts the 128-bit target hash from the processor as four 32-bit register writes and sequences the core through clear, run and stop. It captures the core's matching message block and streams the recovered candidate characters back to the processor as bytes, over a valid/ready handshake. It sits between the processor bus and the brute-force top level, and drives the core's hash and control inputs.

## Interface
Parameters:
- TIMEOUT_W, 32, width of the run-cycle counter; a run times out after 2^TIMEOUT_W−1 cycles
- CLR_CYCLES, 2, number of cycles bf_reset is held before a run

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  host write strobe
- wr_addr  input  2  0=A, 1=B, 2=C, 3=D hash word
- wr_data  input  32  hash word value
- start  input  1  one-cycle pulse; begins a run
- abort  input  1  one-cycle pulse; stops a run
- bf_a, bf_b, bf_c, bf_d  output  32 each  target hash to the core
- bf_ce  output  1  core enable
- bf_reset  output  1  synchronous active-high clear to the core
- bf_find_str  input  1  core match flag
- bf_result_str  input  512  matching padded block; message byte i is at bits [8i+7:8i]
- bf_symb_count  input  4  message length in bytes
- bf_end  input  1  core exhausted its search space
- out_data  output  8  candidate byte
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts a byte
- out_last  output  1  final byte of the candidate
- busy  output  1  high in CLEAR, RUN, CAPTURE or STREAM
- done  output  1  high in DONE
- found  output  1  a match was captured in the last run
- timeout  output  1  the last run hit the cycle limit
- run_cycles  output  TIMEOUT_W  cycles spent in RUN during the last run

## Operation
- Reset values: every output is 0; bf_a..bf_d are 0; the state is IDLE.
- Hash writes are accepted only in IDLE or DONE; a write in any other state is ignored. Writes have no effect on done, found or timeout.
- FSM states: IDLE, CLEAR, RUN, CAPTURE, STREAM, DONE.
- IDLE or DONE, start=1 → CLEAR.
  - On entry to CLEAR: found, timeout and run_cycles are cleared.
- CLEAR: bf_reset=1 and bf_ce=0 for exactly CLR_CYCLES cycles → RUN.
- RUN: bf_ce=1; run_cycles increments by 1 each cycle. Exits are checked in this priority order:
  - abort → IDLE; bf_ce drops on the next edge.
  - bf_find_str → CAPTURE; the block latches bf_result_str and bf_symb_count.
  - bf_end → DONE with found=0.
  - run_cycles reaches 2^TIMEOUT_W−1 → DONE with timeout=1.
- CAPTURE: one cycle; bf_ce=0 and found=1.
  - If the latched count is 0 → DONE.
  - Otherwise the byte index is set to 0 → STREAM.
- STREAM:
  - out_valid=1 and out_data = latched block byte[index].
  - out_last = (index == count−1).
  - On out_valid && out_ready: the index increments; if out_last was set → DONE.
  - out_data, out_valid and out_last are held stable while out_ready=0.
  - abort in STREAM → DONE immediately; the remaining bytes are dropped, and found stays 1.
- DONE: done=1, and the results are held until the next start.
- start in CLEAR, RUN, CAPTURE or STREAM is ignored.
- abort in IDLE, CLEAR or DONE is ignored.
- Asynchronous reset mid-run: all outputs go to 0 immediately, which drops bf_ce; the core is not otherwise cleared until the next CLEAR.

## Timing
- start sampled at edge t: bf_reset=1 from t+1 through t+CLR_CYCLES; bf_ce=1 from t+CLR_CYCLES+1.
- bf_find_str sampled at edge r: CAPTURE at r+1, with bf_ce=0 from r+1. The first out_valid is at r+2.
- Streaming throughput is 1 byte per cycle while out_ready=1. A count of N bytes with out_ready tied high reaches DONE N cycles after the first out_valid.
- run_cycles counts the cycles in which bf_ce=1, including the cycle in which the exit condition is sampled.
- When bf_find_str and bf_end are sampled in the same cycle, find wins. When bf_find_str and abort are sampled in the same cycle, abort wins.

## Test plan
- Write A..D = 0x01234567/0x89ABCDEF/0xFEDCBA98/0x76543210, then start.
  - bf_a..bf_d match the written values.
  - bf_reset is high for exactly 2 cycles, then bf_ce rises.
  - busy=1 throughout.
- In RUN, drive bf_find_str with bf_symb_count=4 and block bytes 0..3 = "abcd", out_ready=1.
  - Exactly 4 beats: 0x61, 0x62, 0x63, 0x64, with out_last only on 0x64.
  - Then done=1 and found=1.
- Repeat with out_ready toggling 1-0-0-1-...
  - out_data is held while out_ready=0.
  - No byte is lost or duplicated.
- In RUN, drive bf_end with no find.
  - DONE with found=0 and timeout=0, no out_valid.
  - run_cycles equals the number of bf_ce cycles.
- Use TIMEOUT_W=4 with the core idle.
  - After 15 RUN cycles: DONE with timeout=1 and run_cycles=15.
- Assert abort in RUN → IDLE, bf_ce=0 the next cycle.
  - A hash write in RUN is ignored.
  - Deasserting reset_n mid-STREAM clears all outputs asynchronously.

Source files
------------

// File: rtl/md5_bf_host_ctrl.sv
// Host-side controller for the MD5 brute-force core: loads the target hash,
// sequences clear/run/stop, captures a match and streams its bytes out.
module md5_bf_host_ctrl #(
  parameter int unsigned TIMEOUT_W  = 32,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [1:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 start,
  input  logic                 abort,
  output logic [31:0]          bf_a,
  output logic [31:0]          bf_b,
  output logic [31:0]          bf_c,
  output logic [31:0]          bf_d,
  output logic                 bf_ce,
  output logic                 bf_reset,
  input  logic                 bf_find_str,
  input  logic [511:0]         bf_result_str,
  input  logic [3:0]           bf_symb_count,
  input  logic                 bf_end,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 timeout,
  output logic [TIMEOUT_W-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [7:0]           CLR_LAST = 8'(CLR_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] RUN_MAX  = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_hash_a, r_hash_b, r_hash_c, r_hash_d;
  logic [7:0]             r_clr_cnt;
  logic [TIMEOUT_W-1:0]   r_run_cycles;
  logic [TIMEOUT_W-1:0]   w_run_next;
  logic                   r_found;
  logic                   r_timeout;
  logic [511:0]           r_block;
  logic [3:0]             r_count;
  logic [3:0]             r_idx;
  logic [7:0]             w_byte;
  logic                   w_streaming;
  logic                   w_last;
  logic                   w_enter_clear;
  logic                   w_find;
  logic                   w_to_hit;
  logic                   w_wr_ok;

  assign w_run_next  = r_run_cycles + 1'b1;
  assign w_streaming = (r_state == S_STREAM);
  assign w_byte      = r_block[{r_idx, 3'b000} +: 8];
  assign w_last      = w_streaming && (r_idx == (r_count - 4'd1));
  assign w_wr_ok     = wr_en && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign bf_a       = r_hash_a;
  assign bf_b       = r_hash_b;
  assign bf_c       = r_hash_c;
  assign bf_d       = r_hash_d;
  assign bf_ce      = (r_state == S_RUN);
  assign bf_reset   = (r_state == S_CLEAR);
  assign busy       = (r_state == S_CLEAR) || (r_state == S_RUN) ||
                      (r_state == S_CAPTURE) || (r_state == S_STREAM);
  assign done       = (r_state == S_DONE);
  assign out_valid  = w_streaming;
  assign out_last   = w_last;
  assign out_data   = w_streaming ? w_byte : '0;
  assign found      = r_found;
  assign timeout    = r_timeout;
  assign run_cycles = r_run_cycles;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; RUN exits are prioritised abort, find, end, timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_enter_clear = 1'b0;
    w_find        = 1'b0;
    w_to_hit      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt   = S_CLEAR;
          w_enter_clear = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_clr_cnt == CLR_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (bf_find_str) begin
          w_state_nxt = S_CAPTURE;
          w_find      = 1'b1;
        end else if (bf_end) begin
          w_state_nxt = S_DONE;
        end else if (w_run_next == RUN_MAX) begin
          w_state_nxt = S_DONE;
          w_to_hit    = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = (r_count == 4'd0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (abort)                    w_state_nxt = S_DONE;
        else if (out_ready && w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Target hash registers, writable only while the core is not in use.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hash_a <= '0;
      r_hash_b <= '0;
      r_hash_c <= '0;
      r_hash_d <= '0;
    end else if (w_wr_ok) begin
      case (wr_addr)
        2'd0: r_hash_a <= wr_data;
        2'd1: r_hash_b <= wr_data;
        2'd2: r_hash_c <= wr_data;
        default: r_hash_d <= wr_data;
      endcase
    end
  end

  // Run bookkeeping, match capture and stream byte index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_cnt    <= '0;
      r_run_cycles <= '0;
      r_found      <= 1'b0;
      r_timeout    <= 1'b0;
      r_block      <= '0;
      r_count      <= '0;
      r_idx        <= '0;
    end else begin
      if (w_enter_clear) begin
        r_clr_cnt    <= '0;
        r_run_cycles <= '0;
        r_found      <= 1'b0;
        r_timeout    <= 1'b0;
      end
      case (r_state)
        S_CLEAR: r_clr_cnt <= r_clr_cnt + 8'd1;
        S_RUN: begin
          r_run_cycles <= w_run_next;
          if (w_find) begin
            r_block <= bf_result_str;
            r_count <= bf_symb_count;
            r_found <= 1'b1;
          end
          if (w_to_hit) r_timeout <= 1'b1;
        end
        S_CAPTURE: r_idx <= '0;
        S_STREAM: begin
          if (out_ready && !abort) r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_bf_host_ctrl.sv
// Directed self-checking bench for md5_bf_host_ctrl.
module tb_md5_bf_host_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         start;
  logic         abort;
  logic [31:0]  bf_a, bf_b, bf_c, bf_d;
  logic         bf_ce, bf_reset;
  logic         bf_find_str;
  logic [511:0] bf_result_str;
  logic [3:0]   bf_symb_count;
  logic         bf_end;
  logic [7:0]   out_data;
  logic         out_valid, out_ready, out_last;
  logic         busy, done, found, timeout;
  logic [31:0]  run_cycles;

  // Second instance with a short timeout counter; its core inputs stay idle.
  logic         start4;
  logic         zero4;
  logic [31:0]  a4, b4, c4, d4;
  logic         ce4, rst4;
  logic [7:0]   od4;
  logic         ov4, ol4, busy4, done4, found4, to4;
  logic [3:0]   rc4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  md5_bf_host_ctrl #(.TIMEOUT_W(32), .CLR_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .abort(abort),
    .bf_a(bf_a), .bf_b(bf_b), .bf_c(bf_c), .bf_d(bf_d),
    .bf_ce(bf_ce), .bf_reset(bf_reset), .bf_find_str(bf_find_str),
    .bf_result_str(bf_result_str), .bf_symb_count(bf_symb_count),
    .bf_end(bf_end), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .found(found), .timeout(timeout), .run_cycles(run_cycles)
  );

  md5_bf_host_ctrl #(.TIMEOUT_W(4), .CLR_CYCLES(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .wr_en(zero4), .wr_addr(2'd0),
    .wr_data(32'd0), .start(start4), .abort(zero4),
    .bf_a(a4), .bf_b(b4), .bf_c(c4), .bf_d(d4),
    .bf_ce(ce4), .bf_reset(rst4), .bf_find_str(zero4),
    .bf_result_str(512'd0), .bf_symb_count(4'd0),
    .bf_end(zero4), .out_data(od4), .out_valid(ov4),
    .out_ready(1'b1), .out_last(ol4), .busy(busy4), .done(done4),
    .found(found4), .timeout(to4), .run_cycles(rc4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_hash(input logic [1:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // start pulse, then two CLEAR cycles; returns observing the first RUN cycle
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hello [5];
    logic [3:0] pat;
    int b;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; abort = 1'b0; bf_find_str = 1'b0; bf_end = 1'b0;
    bf_result_str = '0; bf_symb_count = '0; out_ready = 1'b0;
    start4 = 1'b0; zero4 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_bf_a", bf_a, 0);
    check("rst_bf_ce", bf_ce, 0);
    check("rst_bf_reset", bf_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_run_cycles", run_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Hash load
    write_hash(2'd0, 32'h01234567);
    write_hash(2'd1, 32'h89ABCDEF);
    write_hash(2'd2, 32'hFEDCBA98);
    write_hash(2'd3, 32'h76543210);
    check("hash_a", bf_a, 32'h01234567);
    check("hash_b", bf_b, 32'h89ABCDEF);
    check("hash_c", bf_c, 32'hFEDCBA98);
    check("hash_d", bf_d, 32'h76543210);

    // Clear sequence: bf_reset for exactly two cycles, then bf_ce
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr1_reset", bf_reset, 1);
    check("clr1_ce", bf_ce, 0);
    check("clr1_busy", busy, 1);
    tick();
    check("clr2_reset", bf_reset, 1);
    check("clr2_ce", bf_ce, 0);
    tick();
    check("run_reset", bf_reset, 0);
    check("run_ce", bf_ce, 1);
    check("run_busy", busy, 1);

    // Match "abcd", sink always ready
    bf_result_str = {512{1'b1}};
    bf_result_str[31:0] = 32'h64636261;
    bf_symb_count = 4'd4;
    bf_find_str = 1'b1;
    out_ready = 1'b1;
    tick();
    bf_find_str = 1'b0;
    check("cap_ce", bf_ce, 0);
    check("cap_found", found, 1);
    check("cap_valid", out_valid, 0);
    check("cap_run_cycles", run_cycles, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("abcd_valid", out_valid, 1);
      check("abcd_data", out_data, 8'h61 + i);
      check("abcd_last", out_last, (i == 3) ? 1 : 0);
      tick();
    end
    check("abcd_done", done, 1);
    check("abcd_found", found, 1);
    check("abcd_valid_end", out_valid, 0);
    check("abcd_busy_end", busy, 0);

    // Match "HELLO" with out_ready toggling 1-0-0-1
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_found_cleared", found, 0);
    check("clr_run_cycles_cleared", run_cycles, 0);
    tick();
    tick();
    bf_result_str = '0;
    bf_result_str[39:0] = 40'h4F4C4C4548;
    bf_symb_count = 4'd5;
    bf_find_str = 1'b1;
    tick();
    bf_find_str = 1'b0;
    tick();
    pat = 4'b1001;
    b = 0;
    for (int c = 0; c < 30 && b < 5; c++) begin
      out_ready = pat[c % 4];
      check("hello_valid", out_valid, 1);
      check("hello_data", out_data, hello[b]);
      check("hello_last", out_last, (b == 4) ? 1 : 0);
      tick();
      if (out_ready) b++;
    end
    check("hello_beats", b, 5);
    check("hello_done", done, 1);
    check("hello_valid_end", out_valid, 0);
    out_ready = 1'b1;

    // Search space exhausted: four bf_ce cycles, no find
    start_run();
    tick();
    tick();
    tick();
    bf_end = 1'b1;
    tick();
    bf_end = 1'b0;
    check("end_done", done, 1);
    check("end_found", found, 0);
    check("end_timeout", timeout, 0);
    check("end_valid", out_valid, 0);
    check("end_run_cycles", run_cycles, 4);

    // find and end together: find wins; zero-length match skips streaming
    start_run();
    bf_symb_count = 4'd0;
    bf_find_str = 1'b1;
    bf_end = 1'b1;
    tick();
    bf_find_str = 1'b0;
    bf_end = 1'b0;
    check("both_found", found, 1);
    check("both_capture_busy", busy, 1);
    tick();
    check("zero_len_done", done, 1);
    check("zero_len_valid", out_valid, 0);

    // Write ignored in RUN; abort beats a simultaneous find
    start_run();
    write_hash(2'd0, 32'hDEADBEEF);
    check("run_write_ignored", bf_a, 32'h01234567);
    abort = 1'b1;
    bf_find_str = 1'b1;
    bf_symb_count = 4'd4;
    tick();
    abort = 1'b0;
    bf_find_str = 1'b0;
    check("abort_ce", bf_ce, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_found", found, 0);

    // Timeout on the 4-bit counter instance
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    check("to_ce", ce4, 1);
    repeat (14) tick();
    check("to_not_yet", done4, 0);
    check("to_rc14", rc4, 14);
    tick();
    check("to_done", done4, 1);
    check("to_flag", to4, 1);
    check("to_rc", rc4, 15);
    check("to_found", found4, 0);

    // Asynchronous reset while streaming
    bf_result_str = '0;
    bf_result_str[31:0] = 32'h64636261;
    bf_symb_count = 4'd4;
    start_run();
    bf_find_str = 1'b1;
    tick();
    bf_find_str = 1'b0;
    out_ready = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data", out_data, 8'h61);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_found", found, 0);
    check("arst_busy", busy, 0);
    check("arst_bf_a", bf_a, 0);
    check("arst_ce", bf_ce, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
